ixu_issue_sched: RTL and testbench
==================================

IXU_ISSUE_SCHED -- requirements
Module: ixu_issue_sched

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 2, meaning integer slots per VLIW bundle (legal 1..4).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port flush  in  1  synchronous abort of the current bundle.
REQ-005 SHALL have port bndl_valid  in  1  bundle offered.
REQ-006 SHALL have port bndl_ready  out  1  scheduler can accept a bundle.
REQ-007 SHALL have port bndl_inst  in  32*NUM_SLOTS  slot i at bits [32i+31:32i].
REQ-008 SHALL have port iss_valid  out  1  instruction presented to the shared ALU/decode path.
REQ-009 SHALL have port iss_ready  in  1  ALU accepts the presented instruction.
REQ-010 SHALL have port iss_inst  out  32  instruction being issued.
REQ-011 SHALL have port iss_slot  out  2  slot index of iss_inst.
REQ-012 SHALL have port res_valid  in  1  ALU completion strobe.
REQ-013 SHALL have port res_slot  in  2  slot index of the completing op.
REQ-014 SHALL have port done_valid  out  1  one-cycle bundle-complete pulse.
REQ-015 SHALL have port done_illegal  out  1  bundle held an illegal slot; valid with done_valid.
REQ-016 SHALL have port done_err  out  1  res_slot mismatch seen in the bundle; valid with done_valid.
REQ-017 SHALL have port busy  out  1  state is not IDLE.
REQ-018 SHALL have port op_count  out  16  total ops completed, wraps 0xFFFF->0x0000.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, WAIT, DONE.
REQ-020 SHALL classify each slot at acceptance: NOP if inst==32'h0; legal if opcode inst[6:0] is 7'b0110011 or 7'b0010011; otherwise illegal.
REQ-021 SHALL, in IDLE, drive bndl_ready=1, and in all other states bndl_ready=0.
REQ-022 SHALL, on bndl_valid&&bndl_ready, latch all slots, set pending mask = legal slots and illegal mask = illegal slots, and clear err.
REQ-023 SHALL go from IDLE to ISSUE if the pending mask is nonzero, else to DONE.
REQ-024 SHALL, in ISSUE, drive iss_valid=1, iss_inst=latched[ptr] and iss_slot=ptr, where ptr is the lowest set pending bit, and hold them stable until iss_ready.
REQ-025 SHALL move from ISSUE to WAIT on iss_valid&&iss_ready; iss_valid=0 in all other states.
REQ-026 SHALL keep at most one op outstanding and ignore res_valid outside WAIT.
REQ-027 SHALL, in WAIT on res_valid, clear pending[ptr], increment op_count, set err if res_slot!=ptr, then go to ISSUE if pending remains, else DONE.
REQ-028 SHALL never issue NOP or illegal slots and SHALL issue legal slots in ascending index order.
REQ-029 SHALL, in DONE, assert done_valid=1 for exactly one cycle with done_illegal=|illegal mask and done_err=err, then return to IDLE.
REQ-030 SHALL drive done_illegal and done_err to 0 when done_valid=0.
REQ-031 SHALL give latency with a zero-wait ALU (iss_ready=1, res_valid the cycle after issue) of done_valid at cycle 2k+1 after the accept edge for k legal slots, and cycle 1 for k=0.
REQ-032 SHALL, on flush (rst_n high) in any state, go to IDLE next cycle, clear the masks, and produce no done_valid; op_count is kept.
REQ-033 SHALL give flush priority over res_valid, iss_ready and bndl_valid in the same cycle, and a bndl_valid in a flush cycle SHALL NOT be accepted.
REQ-034 SHALL ignore a late res_valid for a flushed op, since it arrives in IDLE.
REQ-035 SHALL ignore slot index bits above NUM_SLOTS-1 and drive iss_slot upper bits to 0.

Reset
REQ-036 SHALL, with rst_n=0 sampled at a rising edge, go to IDLE, clear pending/illegal/err, and zero op_count, overriding flush and all inputs.
REQ-037 SHALL drive these output values during and after reset: bndl_ready=1, iss_valid=0, iss_inst=0, iss_slot=0, done_valid=0, done_illegal=0, done_err=0, busy=0, op_count=0.
REQ-038 SHALL, on reset mid-bundle (ISSUE/WAIT), abandon the bundle with no done pulse.

Verification
REQ-039 Bench SHALL cover: bundle {slot0=0x00208033 add, slot1=0x00500093 addi}, iss_ready=1, 1-cycle result -> issues slot0 then slot1, done_valid at cycle 5 with illegal=0 and err=0, op_count=2.
REQ-040 Bench SHALL cover: bundle {0x00000000, 0x00000000} -> no iss_valid, done_valid at cycle 1, op_count unchanged.
REQ-041 Bench SHALL cover: bundle {0x0000006F, 0x00208033} -> only slot1 issued with iss_slot=1, done_illegal=1.
REQ-042 Bench SHALL cover: iss_ready low for 3 cycles -> iss_inst/iss_slot stable, bndl_ready=0 throughout; and res_slot=1 while ptr=0 -> done_err=1.
REQ-043 Bench SHALL cover: flush in WAIT, then res_valid next cycle -> IDLE, no done pulse, op_count unchanged, new bundle accepted normally.
REQ-044 Bench SHALL cover: op_count preset to 0xFFFF via 65535 completions, one more completion -> 0x0000; and rst_n=0 mid-ISSUE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ixu_issue_sched.sv
// Issue scheduler for a VLIW bundle: steps the legal slots of one bundle, lowest index
// first, through a shared single-outstanding ALU and reports completion per bundle.
module ixu_issue_sched #(
  parameter int NUM_SLOTS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    bndl_valid,
  output logic                    bndl_ready,
  input  logic [32*NUM_SLOTS-1:0] bndl_inst,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [31:0]             iss_inst,
  output logic [1:0]              iss_slot,
  input  logic                    res_valid,
  input  logic [1:0]              res_slot,
  output logic                    done_valid,
  output logic                    done_illegal,
  output logic                    done_err,
  output logic                    busy,
  output logic [15:0]             op_count
);

  // state | meaning
  // IDLE  | waiting for a bundle, bndl_ready high
  // ISSUE | presenting the lowest pending legal slot to the ALU
  // WAIT  | one op outstanding, waiting for res_valid
  // DONE  | one-cycle completion pulse with illegal/err flags
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Only the low slot-index bits that can address a real slot take part in the compare.
  localparam logic [1:0] SLOT_MASK = 2'(NUM_SLOTS > 2 ? 3 : NUM_SLOTS - 1);

  state_t                  state, state_nxt;
  logic [32*NUM_SLOTS-1:0] slot_bus;
  logic [NUM_SLOTS-1:0]    pending, illegal;
  logic [NUM_SLOTS-1:0]    legal_in, illegal_in;
  logic [NUM_SLOTS-1:0]    ptr_oh;
  logic [1:0]              ptr;
  logic [31:0]             sel_inst;
  logic                    err;
  logic [15:0]             op_cnt;

  always_comb begin
    legal_in   = '0;
    illegal_in = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bndl_inst[32*i +: 32] != 32'h0) begin
        if (bndl_inst[32*i +: 7] == 7'b0110011 || bndl_inst[32*i +: 7] == 7'b0010011)
          legal_in[i] = 1'b1;
        else
          illegal_in[i] = 1'b1;
      end
    end
  end

  // Descending scan so the lowest set pending bit wins.
  always_comb begin
    ptr    = '0;
    ptr_oh = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        ptr    = 2'(i);
        ptr_oh = '0;
        ptr_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_inst = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (ptr == 2'(i)) sel_inst = slot_bus[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bndl_ready   = 1'b0;
    iss_valid    = 1'b0;
    iss_inst     = '0;
    iss_slot     = '0;
    done_valid   = 1'b0;
    done_illegal = 1'b0;
    done_err     = 1'b0;
    case (state)
      IDLE: begin
        bndl_ready = 1'b1;
        if (bndl_valid) state_nxt = (|legal_in) ? ISSUE : DONE;
      end
      ISSUE: begin
        iss_valid = 1'b1;
        iss_inst  = sel_inst;
        iss_slot  = ptr;
        if (iss_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (res_valid) state_nxt = (|(pending & ~ptr_oh)) ? ISSUE : DONE;
      end
      DONE: begin
        done_valid   = 1'b1;
        done_illegal = |illegal;
        done_err     = err;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_bus <= '0;
      pending  <= '0;
      illegal  <= '0;
      err      <= 1'b0;
      op_cnt   <= '0;
    end else if (flush) begin
      pending <= '0;
      illegal <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bndl_valid) begin
            slot_bus <= bndl_inst;
            pending  <= legal_in;
            illegal  <= illegal_in;
            err      <= 1'b0;
          end
        end
        WAIT: begin
          if (res_valid) begin
            pending <= pending & ~ptr_oh;
            op_cnt  <= op_cnt + 16'd1;
            if ((res_slot & SLOT_MASK) != ptr) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign op_count = op_cnt;

endmodule

// File: tb/tb_ixu_issue_sched.sv
// Directed bench for ixu_issue_sched: stimulus queues expected issues/done pulses,
// a forked monitor pops and compares them whenever the DUT presents them.
module tb_ixu_issue_sched;
  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            rst_n, flush, bndl_valid, bndl_ready;
  logic [32*NS-1:0] bndl_inst;
  logic            iss_valid, iss_ready;
  logic [31:0]     iss_inst;
  logic [1:0]      iss_slot, res_slot;
  logic            res_valid, done_valid, done_illegal, done_err, busy;
  logic [15:0]     op_count;

  typedef struct { logic [31:0] inst; logic [1:0] slot; } iss_t;
  typedef struct { logic ill; logic err; } done_t;

  iss_t  exp_iss[$];
  done_t exp_done[$];
  int    nchk = 0;
  int    nfail = 0;
  int    done_cnt = 0;

  localparam logic [31:0] ADD  = 32'h00208033;
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] ADD2 = 32'h00310133;
  localparam logic [31:0] ADD3 = 32'h00418193;
  localparam logic [31:0] JAL  = 32'h0000006F;

  always #5 clk = ~clk;

  ixu_issue_sched #(.NUM_SLOTS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .bndl_valid(bndl_valid), .bndl_ready(bndl_ready), .bndl_inst(bndl_inst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst(iss_inst), .iss_slot(iss_slot),
    .res_valid(res_valid), .res_slot(res_slot),
    .done_valid(done_valid), .done_illegal(done_illegal), .done_err(done_err),
    .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    nchk++;
    nfail++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  task automatic push_iss(input logic [31:0] inst, input logic [1:0] slot);
    iss_t e;
    e.inst = inst;
    e.slot = slot;
    exp_iss.push_back(e);
  endtask

  task automatic push_done(input logic ill, input logic err);
    done_t d;
    d.ill = ill;
    d.err = err;
    exp_done.push_back(d);
  endtask

  // Offers one bundle from IDLE and plays a zero-wait ALU, with an optional initial
  // iss_ready stall and an optional wrong res_slot on the first completion.
  task automatic run_bundle(input logic [32*NS-1:0] insts, input int stall, input logic bad,
                            output int lat);
    logic        res_pend, first, have_hold;
    logic [1:0]  last_slot, hold_slot;
    logic [31:0] hold_inst;
    int          cyc;
    bndl_valid = 1'b1;
    bndl_inst  = insts;
    @(posedge clk); #1;
    bndl_valid = 1'b0;
    bndl_inst  = '0;
    res_pend = 1'b0; first = 1'b1; have_hold = 1'b0;
    last_slot = '0; hold_slot = '0; hold_inst = '0;
    cyc = 1;
    lat = -1;
    while (cyc < 64) begin
      if (done_valid) begin
        lat = cyc;
        break;
      end
      res_valid = res_pend;
      res_slot  = (bad && first) ? (last_slot ^ 2'd1) : last_slot;
      if (res_pend) first = 1'b0;
      res_pend = 1'b0;
      iss_ready = 1'b0;
      if (iss_valid) begin
        if (stall > 0) begin
          if (have_hold) begin
            chk("stall_iss_inst", iss_inst, hold_inst);
            chk("stall_iss_slot", 32'(iss_slot), 32'(hold_slot));
          end else begin
            have_hold = 1'b1;
            hold_inst = iss_inst;
            hold_slot = iss_slot;
          end
          chk("stall_bndl_ready", 32'(bndl_ready), 0);
          stall--;
        end else begin
          iss_ready = 1'b1;
          res_pend  = 1'b1;
          last_slot = iss_slot;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    res_valid = 1'b0;
    iss_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int done_before;
    rst_n = 1'b0; flush = 1'b0; bndl_valid = 1'b0; bndl_inst = '0;
    iss_ready = 1'b0; res_valid = 1'b0; res_slot = '0;

    fork
      begin : monitor
        iss_t  e;
        done_t d;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (iss_valid && iss_ready) begin
              if (exp_iss.size() == 0) fail_now("unexpected_issue");
              else begin
                e = exp_iss.pop_front();
                chk("iss_inst", iss_inst, e.inst);
                chk("iss_slot", 32'(iss_slot), 32'(e.slot));
              end
            end
            if (done_valid) begin
              done_cnt++;
              if (exp_done.size() == 0) fail_now("unexpected_done");
              else begin
                d = exp_done.pop_front();
                chk("done_illegal", 32'(done_illegal), 32'(d.ill));
                chk("done_err", 32'(done_err), 32'(d.err));
              end
            end else begin
              chk("done_flags_idle", {30'b0, done_illegal, done_err}, 0);
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_bndl_ready", 32'(bndl_ready), 1);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two legal slots, zero-wait ALU.
    push_iss(ADD, 2'd0); push_iss(ADDI, 2'd1); push_done(1'b0, 1'b0);
    run_bundle({32'h0, 32'h0, ADDI, ADD}, 0, 1'b0, lat);
    chk("t1_latency", 32'(lat), 5);
    chk("t1_op_count", 32'(op_count), 2);

    // All-NOP bundle.
    push_done(1'b0, 1'b0);
    run_bundle('0, 0, 1'b0, lat);
    chk("t2_latency", 32'(lat), 1);
    chk("t2_op_count", 32'(op_count), 2);

    // Illegal slot 0, legal slot 1.
    push_iss(ADD, 2'd1); push_done(1'b1, 1'b0);
    run_bundle({32'h0, 32'h0, ADD, JAL}, 0, 1'b0, lat);
    chk("t3_latency", 32'(lat), 3);
    chk("t3_op_count", 32'(op_count), 3);

    // Three-cycle iss_ready stall plus a wrong res_slot on the first result.
    push_iss(ADD, 2'd0); push_iss(ADDI, 2'd1); push_done(1'b0, 1'b1);
    run_bundle({32'h0, 32'h0, ADDI, ADD}, 3, 1'b1, lat);
    chk("t4_latency", 32'(lat), 8);
    chk("t4_op_count", 32'(op_count), 5);

    // Flush in WAIT, late result in IDLE.
    done_before = done_cnt;
    push_iss(ADD, 2'd0);
    bndl_valid = 1'b1; bndl_inst = {32'h0, 32'h0, ADDI, ADD};
    @(posedge clk); #1;
    bndl_valid = 1'b0; bndl_inst = '0;
    chk("t5_issue_valid", 32'(iss_valid), 1);
    iss_ready = 1'b1;
    @(posedge clk); #1;
    iss_ready = 1'b0;
    chk("t5_wait_busy", 32'(busy), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t5_flush_idle", 32'(busy), 0);
    res_valid = 1'b1; res_slot = 2'd0;
    @(posedge clk); #1;
    res_valid = 1'b0;
    chk("t5_late_res_busy", 32'(busy), 0);
    chk("t5_op_count", 32'(op_count), 5);
    // A bundle offered during flush is not taken.
    flush = 1'b1; bndl_valid = 1'b1; bndl_inst = {32'h0, 32'h0, ADDI, ADD};
    @(posedge clk); #1;
    flush = 1'b0; bndl_valid = 1'b0; bndl_inst = '0;
    chk("t5_flush_no_accept", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", 32'(done_cnt), 32'(done_before));
    push_iss(ADD, 2'd0); push_iss(ADDI, 2'd1); push_done(1'b0, 1'b0);
    run_bundle({32'h0, 32'h0, ADDI, ADD}, 0, 1'b0, lat);
    chk("t5_after_latency", 32'(lat), 5);
    chk("t5_after_op_count", 32'(op_count), 7);

    // Fill op_count to 0xFFFF with four-op bundles, then wrap.
    for (int b = 0; b < 16382; b++) begin
      push_iss(ADD, 2'd0); push_iss(ADDI, 2'd1); push_iss(ADD2, 2'd2); push_iss(ADD3, 2'd3);
      push_done(1'b0, 1'b0);
      run_bundle({ADD3, ADD2, ADDI, ADD}, 0, 1'b0, lat);
      if (lat != 9) chk("t6_bulk_latency", 32'(lat), 9);
    end
    chk("t6_op_count_ffff", 32'(op_count), 32'h0000FFFF);
    push_iss(ADD, 2'd0); push_done(1'b0, 1'b0);
    run_bundle({32'h0, 32'h0, 32'h0, ADD}, 0, 1'b0, lat);
    chk("t6_wrap_latency", 32'(lat), 3);
    chk("t6_op_count_wrap", 32'(op_count), 0);

    // Reset while in ISSUE.
    push_iss(ADD, 2'd0);
    push_done(1'b1, 1'b0);
    run_bundle({32'h0, 32'h0, JAL, ADD}, 0, 1'b0, lat);
    chk("t7_pre_op_count", 32'(op_count), 1);
    bndl_valid = 1'b1; bndl_inst = {32'h0, 32'h0, ADDI, ADD};
    @(posedge clk); #1;
    bndl_valid = 1'b0; bndl_inst = '0;
    chk("t7_in_issue", 32'(iss_valid), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t7_rst_bndl_ready", 32'(bndl_ready), 1);
    chk("t7_rst_iss_valid", 32'(iss_valid), 0);
    chk("t7_rst_iss_inst", iss_inst, 0);
    chk("t7_rst_iss_slot", 32'(iss_slot), 0);
    chk("t7_rst_done", {29'b0, done_valid, done_illegal, done_err}, 0);
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_op_count", 32'(op_count), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("end_iss_queue_empty", 32'(exp_iss.size()), 0);
    chk("end_done_queue_empty", 32'(exp_done.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
